regfile_wb_scheduler: RTL and testbench
=======================================

# regfile_wb_scheduler

Writeback scheduler and scoreboard for the 64-bit RegisterFile in NeanderRV64. It shares the RegisterFile's single write port between two writeback sources, the ALU (source 0) and the load/store unit (source 1), using a round-robin arbiter with a valid/ready handshake. It also keeps a per-register busy scoreboard so the decode stage can stall on RAW and WAW hazards. It sits between the execute/memory stages and the RegisterFile write port.

## Interface
Parameters:
- N, 64, data width; equals RegisterFile N.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_valid  in  2  per-source writeback request; bit i belongs to source i.
- wb_rd  in  2x5  per-source destination register.
- wb_data  in  2xN  per-source write data.
- wb_ready  out  2  per-source grant; a transfer happens when valid & ready are both high.
- issue_valid  in  1  decode issues an instruction that writes issue_rd.
- issue_rd  in  5  destination of the issuing instruction.
- issue_ready  out  1  low when issue_rd is busy (WAW stall).
- rs1, rs2  in  5 each  decode read addresses.
- rs1_busy, rs2_busy  out  1 each  operand still pending a writeback (RAW stall).
- writeEnable  out  1  drives RegisterFile writeEnable.
- rd  out  5  drives RegisterFile rd.
- writerData  out  N  drives RegisterFile writerData.

## Operation
- Arbiter keeps a 1-bit last-granted pointer `last`; reset value is 1, so source 0 has first priority.
- wb_ready is combinational:
  - only one source valid: that source is granted;
  - both valid: the source != last is granted;
  - at most one bit of wb_ready is high in any cycle.
- On an accepted transfer:
  - `last` updates to the granted index;
  - the output registers capture the granted rd and data;
  - writeEnable is registered as 1, but forced to 0 when rd == 0.
- With no transfer, writeEnable is 0 next cycle. rd and writerData hold their last values.
- A source must hold valid, rd and data stable until it is granted. No buffering beyond the output register; throughput is one write per cycle.
- Scoreboard: 32-bit busy mask; bit 0 is hardwired 0.
  - Set: issue_valid & issue_ready & issue_rd != 0 sets busy[issue_rd].
  - Clear: the cycle writeEnable is 1 clears busy[rd] at the posedge that commits the RegisterFile write.
  - Set and clear on the same register in the same cycle: set wins.
- Combinational outputs:
  - rsX_busy = busy[rsX];
  - issue_ready = !busy[issue_rd], forced to 1 when issue_rd == 0.
- A writeback to a non-busy register is legal. It is written and the mask is unchanged.

## Timing
- Reset (async assert, sync deassert upstream): busy = 0, last = 1, writeEnable = 0, rd = 0, writerData = 0, wb_ready follows inputs.
- Handshake accepted in cycle T → writeEnable/rd/writerData valid during T+1 → RegisterFile updated and busy bit cleared at the posedge ending T+1.
- A reader stalled on rsX_busy sees it drop in T+2, and the RegisterFile already holds the new value then.
- Back-to-back contention alternates grants each cycle: 0,1,0,1 when both stay valid.
- Reset mid-transfer: a pending output write is dropped and all busy bits cleared. Sources re-present after reset.

## Structure
- The shared package holds REG_COUNT = 32, REG_ADDR_W = 5, NUM_WB_SRC = 2, and the wb_req_t struct {rd, data}.
- One sub-module, rr_arbiter2: the 2-way round-robin grant plus pointer. The scoreboard and output registers stay in the top module.

## Test plan
- Reset: hold rst_n=0, then release → writeEnable=0, rs1_busy=rs2_busy=0, issue_ready=1.
- Issue x5, then source 0 writes x5=0xA1 → rs1_busy (rs1=5) is 1 until the write commits. RegisterFile x5 reads 0xA1 when rs1_busy drops. writeEnable pulses exactly one cycle.
- Both sources valid for 4 cycles (src0 x1=0x10, src1 x2=0x20, each re-presenting new data after a grant) → grants alternate 0,1,0,1 starting with 0 after reset.
- Issue x3 while x3 is busy → issue_ready=0, mask unchanged. Issue to x0 → issue_ready=1 and busy[0] stays 0.
- Source 1 writes x0=0xFFFF_FFFF_FFFF_FFFF → writeEnable stays 0 and the RegisterFile x0 reads 0.
- Same cycle: issue x4 while the write to x4 commits → busy[4] remains 1. Assert rst_n=0 with a write pending → writeEnable=0 immediately and the mask is cleared.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and types for the NeanderRV64 writeback scheduler.
package regfile_wb_scheduler_pkg;

    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_WB_SRC = 2;
    localparam int unsigned XLEN       = 64;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback request bundle: per-source valid/rd/data with a per-source ready.
interface regfile_wb_scheduler_if
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int unsigned N = XLEN
);
    logic [NUM_WB_SRC-1:0] wb_valid;
    logic [NUM_WB_SRC-1:0] wb_ready;
    logic [REG_ADDR_W-1:0] wb_rd   [NUM_WB_SRC];
    logic [N-1:0]          wb_data [NUM_WB_SRC];

    modport master (output wb_valid, output wb_rd, output wb_data, input wb_ready);
    modport slave  (input wb_valid, input wb_rd, input wb_data, output wb_ready);
endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the last-granted pointer resets to 1 so source 0 wins first.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] ready,
    output logic       grantIdx
);

    logic last;

    always_comb begin
        ready    = 2'b00;
        grantIdx = 1'b0;
        unique case (valid)
            2'b01: ready = 2'b01;
            2'b10: begin
                ready    = 2'b10;
                grantIdx = 1'b1;
            end
            2'b11: begin
                // Contention: favour whichever source was not granted last.
                grantIdx = ~last;
                ready    = last ? 2'b01 : 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (|ready) begin
            last <= grantIdx;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the RegisterFile write port between ALU and LSU writebacks and tracks
// per-register busy bits so decode can stall on RAW/WAW hazards.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int unsigned N = XLEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wb_scheduler_if.slave  wb,
    input  logic                   issue_valid,
    input  logic [REG_ADDR_W-1:0]  issue_rd,
    output logic                   issue_ready,
    input  logic [REG_ADDR_W-1:0]  rs1,
    input  logic [REG_ADDR_W-1:0]  rs2,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   writeEnable,
    output logic [REG_ADDR_W-1:0]  rd,
    output logic [N-1:0]           writerData
);

    logic                 grantIdx;
    logic                 accept;
    wb_req_t              grantReq;
    logic [REG_COUNT-1:0] busyQ;
    logic [REG_COUNT-1:0] busyD;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (wb.wb_valid),
        .ready    (wb.wb_ready),
        .grantIdx (grantIdx)
    );

    // Ready is only ever raised for a valid source, so any ready bit is a transfer.
    assign accept = |wb.wb_ready;

    always_comb begin
        grantReq.rd   = wb.wb_rd[grantIdx];
        grantReq.data = wb.wb_data[grantIdx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writeEnable <= 1'b0;
            rd          <= '0;
            writerData  <= '0;
        end else if (accept) begin
            writeEnable <= (grantReq.rd != '0);
            rd          <= grantReq.rd;
            writerData  <= grantReq.data;
        end else begin
            writeEnable <= 1'b0;
        end
    end

    assign issue_ready = (issue_rd == '0) || !busyQ[issue_rd];
    assign rs1_busy    = busyQ[rs1];
    assign rs2_busy    = busyQ[rs2];

    // Clear first so a same-cycle issue to the committing register keeps it busy.
    always_comb begin
        busyD = busyQ;
        if (writeEnable) begin
            busyD[rd] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            busyD[issue_rd] = 1'b1;
        end
        busyD[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyQ <= '0;
        end else begin
            busyQ <= busyD;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench: stimulus queues expected grants/writes, a negedge monitor pops and checks.
module tb_regfile_wb_scheduler;
    import regfile_wb_scheduler_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            writeEnable;
    logic [4:0]      rd;
    logic [63:0]     writerData;

    int errors = 0;
    int checks = 0;

    logic [1:0] expGrant[$];
    wb_req_t    expWr[$];
    logic [63:0] regs [32];

    regfile_wb_scheduler_if #(.N(64)) wbIf ();

    regfile_wb_scheduler #(.N(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb          (wbIf.slave),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .writeEnable (writeEnable),
        .rd          (rd),
        .writerData  (writerData)
    );

    always #5 clk = ~clk;

    // Behavioural RegisterFile fed by the DUT write port; x0 is hardwired to zero.
    initial for (int i = 0; i < 32; i++) regs[i] = '0;
    always @(posedge clk) if (writeEnable && rd != 5'd0) regs[rd] <= writerData;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWr(input logic [4:0] r, input logic [63:0] d);
        wb_req_t w;
        w.rd   = r;
        w.data = d;
        expWr.push_back(w);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if ((wbIf.wb_valid & wbIf.wb_ready) != 2'b00) begin
                if (expGrant.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant: got ready=%b expected no transfer", wbIf.wb_ready);
                end else begin
                    check("grant", 64'(wbIf.wb_ready), 64'(expGrant.pop_front()));
                end
            end
            if (writeEnable) begin
                if (expWr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write: got we=1 rd=%0d expected no write", rd);
                end else begin
                    wb_req_t w;
                    w = expWr.pop_front();
                    check("write rd", 64'(rd), 64'(w.rd));
                    check("write data", writerData, w.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        issue_valid = 1'b0;
        issue_rd = 5'd5;
        rs1 = 5'd5;
        rs2 = 5'd3;
        wbIf.wb_valid = 2'b00;
        wbIf.wb_rd[0] = '0;
        wbIf.wb_rd[1] = '0;
        wbIf.wb_data[0] = '0;
        wbIf.wb_data[1] = '0;

        repeat (3) tick();
        check("reset we", 64'(writeEnable), 64'd0);
        check("reset rd", 64'(rd), 64'd0);
        check("reset data", writerData, 64'd0);
        rst_n = 1'b1;
        tick();
        check("post-reset we", 64'(writeEnable), 64'd0);
        check("post-reset rs1_busy", 64'(rs1_busy), 64'd0);
        check("post-reset rs2_busy", 64'(rs2_busy), 64'd0);
        check("post-reset issue_ready", 64'(issue_ready), 64'd1);

        // Contention: grants alternate 0,1,0,1; granted source re-presents new data.
        wbIf.wb_valid = 2'b11;
        wbIf.wb_rd[0] = 5'd1;
        wbIf.wb_data[0] = 64'h10;
        wbIf.wb_rd[1] = 5'd2;
        wbIf.wb_data[1] = 64'h20;
        expGrant.push_back(2'b01); expGrant.push_back(2'b10);
        expGrant.push_back(2'b01); expGrant.push_back(2'b10);
        pushWr(5'd1, 64'h10); pushWr(5'd2, 64'h20);
        pushWr(5'd1, 64'h11); pushWr(5'd2, 64'h21);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k % 2 == 0) wbIf.wb_data[0] = wbIf.wb_data[0] + 64'd1;
            else wbIf.wb_data[1] = wbIf.wb_data[1] + 64'd1;
        end
        wbIf.wb_valid = 2'b00;
        repeat (2) tick();

        // Issue x5 then source 0 writes x5 = 0xA1.
        issue_valid = 1'b1;
        issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        check("x5 busy after issue", 64'(rs1_busy), 64'd1);
        check("x5 WAW stall", 64'(issue_ready), 64'd0);
        wbIf.wb_valid = 2'b01;
        wbIf.wb_rd[0] = 5'd5;
        wbIf.wb_data[0] = 64'hA1;
        expGrant.push_back(2'b01);
        pushWr(5'd5, 64'hA1);
        tick();
        wbIf.wb_valid = 2'b00;
        check("x5 we in T+1", 64'(writeEnable), 64'd1);
        check("x5 still busy T+1", 64'(rs1_busy), 64'd1);
        tick();
        check("x5 busy cleared", 64'(rs1_busy), 64'd0);
        check("x5 regfile value", regs[5], 64'hA1);
        check("x5 we single pulse", 64'(writeEnable), 64'd0);

        // WAW on x3, then issue to x0.
        issue_valid = 1'b1;
        issue_rd = 5'd3;
        tick();
        check("x3 WAW stall", 64'(issue_ready), 64'd0);
        tick();
        issue_valid = 1'b0;
        check("x3 busy", 64'(rs2_busy), 64'd1);
        check("x5 unchanged", 64'(rs1_busy), 64'd0);
        issue_valid = 1'b1;
        issue_rd = 5'd0;
        #1;
        check("x0 issue_ready", 64'(issue_ready), 64'd1);
        tick();
        issue_valid = 1'b0;
        rs1 = 5'd0;
        #1;
        check("x0 never busy", 64'(rs1_busy), 64'd0);

        // Source 1 writes x0: transfer accepted but no write.
        wbIf.wb_valid = 2'b10;
        wbIf.wb_rd[1] = 5'd0;
        wbIf.wb_data[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        expGrant.push_back(2'b10);
        tick();
        wbIf.wb_valid = 2'b00;
        check("x0 write suppressed", 64'(writeEnable), 64'd0);
        tick();
        check("x0 regfile zero", regs[0], 64'd0);

        // Issue x4 in the same cycle its (non-busy) writeback commits: set wins.
        rs1 = 5'd4;
        wbIf.wb_valid = 2'b01;
        wbIf.wb_rd[0] = 5'd4;
        wbIf.wb_data[0] = 64'h44;
        expGrant.push_back(2'b01);
        pushWr(5'd4, 64'h44);
        tick();
        wbIf.wb_valid = 2'b00;
        issue_valid = 1'b1;
        issue_rd = 5'd4;
        #1;
        check("x4 issue_ready", 64'(issue_ready), 64'd1);
        check("x4 we", 64'(writeEnable), 64'd1);
        tick();
        issue_valid = 1'b0;
        check("x4 set wins", 64'(rs1_busy), 64'd1);
        check("x4 regfile value", regs[4], 64'h44);

        // Reset with a write pending in the output register.
        wbIf.wb_valid = 2'b01;
        wbIf.wb_rd[0] = 5'd7;
        wbIf.wb_data[0] = 64'h77;
        expGrant.push_back(2'b01);
        tick();
        rst_n = 1'b0;
        wbIf.wb_valid = 2'b00;
        #1;
        check("reset drops we", 64'(writeEnable), 64'd0);
        check("reset clears x4", 64'(rs1_busy), 64'd0);
        check("reset clears x3", 64'(rs2_busy), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("x7 not written", regs[7], 64'd0);
        check("grant queue drained", 64'(expGrant.size()), 64'd0);
        check("write queue drained", 64'(expWr.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
